// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI byte engine between two requesters and
// sequences multi-byte transactions through it, with a watchdog on a hung END_BIT.
module spi_txn_arbiter #(
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 1200,
    parameter int unsigned LEN_W       = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       txd0,
    input  logic [7:0]       txd1,
    output logic             tx_rd0,
    output logic             tx_rd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [7:0]       rx_data,
    output logic             rx_vld0,
    output logic             rx_vld1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic             busy,

    output logic             spi_start,
    input  logic             spi_end,
    output logic [7:0]       spi_txd,
    input  logic [7:0]       spi_rxd
);

    localparam int unsigned WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StRel,
        StGap,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               abort_q, abort_d;
    logic [7:0]         txd_q, txd_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [1:0]         rx_vld_q, rx_vld_d;
    logic               start_q, start_d;

    logic               any_req;
    logic               pick1;
    logic [LEN_W-1:0]   grant_len;

    // Requester 1 wins when alone, or when both ask and 0 was served last.
    assign any_req   = req0 | req1;
    assign pick1     = req1 & (~req0 | ~last_q);
    assign grant_len = pick1 ? len1 : len0;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rem_d     = rem_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        abort_d   = abort_q;
        txd_d     = txd_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = pick1;
                    rem_d   = grant_len;
                    state_d = (grant_len == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                txd_d   = owner_q ? txd1 : txd0;
                wdog_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                if (spi_end) begin
                    rx_data_d          = spi_rxd;
                    rx_vld_d[owner_q]  = 1'b1;
                    rem_d              = rem_q - LEN_W'(1);
                    state_d            = StRel;
                end else if (wdog_q == WDOG_LAST) begin
                    abort_d = 1'b1;
                    state_d = StDone;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            StRel: begin
                // Master holds END_BIT until it sees START high; wait for it to drop.
                if (!spi_end) begin
                    if (rem_q != '0) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    state_d = StLoad;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            StDone: begin
                last_d  = owner_q;
                abort_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered so START rises on the very edge that leaves RUN.
        start_d = (state_d != StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            rem_q     <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
            abort_q   <= 1'b0;
            txd_q     <= 8'h00;
            rx_data_q <= 8'h00;
            rx_vld_q  <= 2'b00;
            start_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            abort_q   <= abort_d;
            txd_q     <= txd_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            start_q   <= start_d;
        end
    end

    // Grant is visible in the IDLE cycle that accepts the request.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle) begin
            gnt0 = any_req & ~pick1;
            gnt1 = any_req & pick1;
        end else begin
            gnt0 = ~owner_q;
            gnt1 = owner_q;
        end
    end

    assign tx_rd0    = (state_q == StLoad) & ~owner_q;
    assign tx_rd1    = (state_q == StLoad) & owner_q;
    assign done0     = (state_q == StDone) & ~owner_q;
    assign done1     = (state_q == StDone) & owner_q;
    assign err       = (state_q == StDone) & abort_q;
    assign busy      = (state_q != StIdle);
    assign rx_vld0   = rx_vld_q[0];
    assign rx_vld1   = rx_vld_q[1];
    assign rx_data   = rx_data_q;
    assign spi_start = start_q;
    assign spi_txd   = txd_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural SPI master plus a transaction table and
// hand-written sequences for arbitration, watchdog and mid-transaction reset.
module tb_spi_txn_arbiter;

    localparam int GAP   = 8;
    localparam int TMO   = 50;
    localparam int LEN_W = 4;
    localparam int MB    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [LEN_W-1:0] len0 = '0, len1 = '0;
    logic [7:0]       txd0 = 8'h00, txd1 = 8'h00;
    logic             tx_rd0, tx_rd1, gnt0, gnt1;
    logic [7:0]       rx_data;
    logic             rx_vld0, rx_vld1, done0, done1, err, busy;
    logic             spi_start;
    logic             spi_end = 1'b0;
    logic [7:0]       spi_txd;
    logic [7:0]       spi_rxd = 8'h00;

    spi_txn_arbiter #(
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO),
        .LEN_W       (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .txd0      (txd0),
        .txd1      (txd1),
        .tx_rd0    (tx_rd0),
        .tx_rd1    (tx_rd1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rx_data   (rx_data),
        .rx_vld0   (rx_vld0),
        .rx_vld1   (rx_vld1),
        .done0     (done0),
        .done1     (done1),
        .err       (err),
        .busy      (busy),
        .spi_start (spi_start),
        .spi_end   (spi_end),
        .spi_txd   (spi_txd),
        .spi_rxd   (spi_rxd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_src0 [16];
    logic [7:0] tx_src1 [16];
    logic [7:0] rx_src  [16];
    int tx_idx0 = 0, tx_idx1 = 0, rx_idx = 0;
    bit master_en = 1'b1;

    logic [7:0] mosi_log [$];
    logic [7:0] rx_log   [$];
    bit         order_q  [$];
    int n_txrd, n_rx0, n_rx1, n_done0, n_done1, n_err, n_errdone, n_both, n_gntcyc;
    int n_low, n_win, g_cyc, s_cyc, min_gap, hi_run, mcyc;
    bit low_seen, start_prev, gnt_prev;

    typedef struct {
        bit         who;
        int         len;
        bit         stuck;
        logic [7:0] tx [3];
        logic [7:0] rx [3];
        bit         exp_err;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mosi_log.delete();
        rx_log.delete();
        order_q.delete();
        n_txrd = 0; n_rx0 = 0; n_rx1 = 0; n_done0 = 0; n_done1 = 0;
        n_err = 0; n_errdone = 0; n_both = 0; n_gntcyc = 0;
        n_low = 0; n_win = 0; g_cyc = -1; s_cyc = -1;
        min_gap = 9999; hi_run = 0; low_seen = 1'b0;
    endtask

    // SPI master model: END_BIT after MB low cycles, cleared once START is back high.
    int mcnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                spi_end = 1'b0;
                mcnt    = 0;
            end else if (spi_end) begin
                if (spi_start) spi_end = 1'b0;
            end else if (!spi_start && master_en) begin
                if (mcnt == 0) mosi_log.push_back(spi_txd);
                mcnt++;
                if (mcnt == MB) begin
                    spi_end = 1'b1;
                    spi_rxd = rx_src[rx_idx % 16];
                    rx_idx++;
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // TX byte supply: advance to the next byte the cycle after TX_RD.
    initial begin
        bit rd0, rd1;
        forever begin
            @(negedge clk);
            rd0 = tx_rd0;
            rd1 = tx_rd1;
            @(posedge clk);
            #1;
            if (rd0) begin tx_idx0++; txd0 = tx_src0[tx_idx0 % 16]; end
            if (rd1) begin tx_idx1++; txd1 = tx_src1[tx_idx1 % 16]; end
        end
    end

    initial begin
        mcyc = 0; start_prev = 1'b1; gnt_prev = 1'b0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_rd0 || tx_rd1) n_txrd++;
                if (rx_vld0) n_rx0++;
                if (rx_vld1) n_rx1++;
                if (rx_vld0 || rx_vld1) rx_log.push_back(rx_data);
                if (done0) n_done0++;
                if (done1) n_done1++;
                if (done0 || done1) begin
                    order_q.push_back(done1);
                    if (err) n_errdone++;
                end
                if (err) n_err++;
                if (gnt0 && gnt1) n_both++;
                if (gnt0 || gnt1) n_gntcyc++;
                if ((gnt0 || gnt1) && !gnt_prev && g_cyc < 0) g_cyc = mcyc;
                if (!spi_start) begin
                    n_low++;
                    if (start_prev) begin
                        n_win++;
                        if (s_cyc < 0) s_cyc = mcyc;
                    end
                    if (low_seen && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                    low_seen = 1'b1;
                    hi_run   = 0;
                end else begin
                    hi_run++;
                end
            end
            start_prev = spi_start;
            gnt_prev   = gnt0 || gnt1;
            mcyc++;
        end
    end

    task automatic run_txn(input bit who, input int len, input bit stuck, input bit exp_err,
                           input string tag);
        int b;
        int exp_rx;
        logic [7:0] e;
        clear_mon();
        tx_idx0 = 0; tx_idx1 = 0; rx_idx = 0;
        txd0 = tx_src0[0]; txd1 = tx_src1[0];
        master_en = !stuck;
        if (who) begin len1 = len[LEN_W-1:0]; req1 = 1'b1; end
        else     begin len0 = len[LEN_W-1:0]; req0 = 1'b1; end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        b = 0;
        while ((n_done0 + n_done1) == 0 && b < 2000) begin @(posedge clk); #1; b++; end
        repeat (3) @(posedge clk);
        #1;
        master_en = 1'b1;
        exp_rx = stuck ? 0 : len;
        chk({tag, "_done"}, who ? n_done1 : n_done0, 1);
        chk({tag, "_done_other"}, who ? n_done0 : n_done1, 0);
        chk({tag, "_err"}, n_err, exp_err);
        chk({tag, "_err_with_done"}, n_errdone, exp_err);
        chk({tag, "_tx_rd"}, n_txrd, (len == 0) ? 0 : (stuck ? 1 : len));
        chk({tag, "_rx_vld"}, who ? n_rx1 : n_rx0, exp_rx);
        chk({tag, "_rx_vld_other"}, who ? n_rx0 : n_rx1, 0);
        chk({tag, "_start_low_cyc"}, n_low, (len == 0) ? 0 : (stuck ? TMO : len * MB));
        chk({tag, "_start_windows"}, n_win, (len == 0) ? 0 : (stuck ? 1 : len));
        if (len > 0) chk({tag, "_latency"}, s_cyc - g_cyc, 2);
        else         chk({tag, "_gnt_cyc"}, n_gntcyc, 2);
        chk({tag, "_mosi_n"}, mosi_log.size(), exp_rx);
        for (int i = 0; i < mosi_log.size() && i < exp_rx; i++) begin
            e = who ? tx_src1[i] : tx_src0[i];
            chk($sformatf("%s_mosi%0d", tag, i), mosi_log[i], e);
        end
        chk({tag, "_rx_n"}, rx_log.size(), exp_rx);
        for (int i = 0; i < rx_log.size() && i < exp_rx; i++)
            chk($sformatf("%s_rx%0d", tag, i), rx_log[i], rx_src[i]);
        if (exp_rx > 1) chk({tag, "_gap"}, min_gap, GAP + 2);
        if (exp_rx > 0) chk({tag, "_rx_hold"}, rx_data, rx_src[exp_rx - 1]);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_gnt_both"}, n_both, 0);
    endtask

    task automatic set_vec(input int k, input bit who, input int len, input bit stuck,
                           input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                           input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                           input bit exp_err);
        vecs[k].who = who; vecs[k].len = len; vecs[k].stuck = stuck;
        vecs[k].tx[0] = t0; vecs[k].tx[1] = t1; vecs[k].tx[2] = t2;
        vecs[k].rx[0] = r0; vecs[k].rx[1] = r1; vecs[k].rx[2] = r2;
        vecs[k].exp_err = exp_err;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int b;
        set_vec(0, 1'b0, 1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0);
        set_vec(1, 1'b1, 3, 1'b0, 8'h11, 8'h22, 8'h33, 8'hC1, 8'hC2, 8'hC3, 1'b0);
        set_vec(2, 1'b0, 0, 1'b0, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        set_vec(3, 1'b0, 2, 1'b0, 8'h5A, 8'h96, 8'h00, 8'h0F, 8'hF0, 8'h00, 1'b0);
        set_vec(4, 1'b1, 1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        set_vec(5, 1'b1, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        set_vec(6, 1'b0, 1, 1'b1, 8'hE7, 8'h00, 8'h00, 8'h99, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tx_src0[i] = 8'h00; tx_src1[i] = 8'h00; rx_src[i] = 8'h00;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spi_start", spi_start, 1);
        chk("rst_spi_txd", spi_txd, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {tx_rd0, tx_rd1, rx_vld0, rx_vld1, done0, done1, err}, 0);

        // Both requesting from reset: alternate 0,1,0,1
        tx_src0[0] = 8'h10; tx_src0[1] = 8'h11;
        tx_src1[0] = 8'h20; tx_src1[1] = 8'h21;
        for (int i = 0; i < 4; i++) rx_src[i] = 8'h40 + 8'(i);
        tx_idx0 = 0; tx_idx1 = 0; rx_idx = 0;
        txd0 = tx_src0[0]; txd1 = tx_src1[0];
        len0 = 4'd1; len1 = 4'd1;
        clear_mon();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        b = 0;
        while (n_txrd < 4 && b < 2000) begin @(posedge clk); #1; b++; end
        req0 = 1'b0; req1 = 1'b0;
        b = 0;
        while ((n_done0 + n_done1) < 4 && b < 2000) begin @(posedge clk); #1; b++; end
        repeat (3) @(posedge clk);
        #1;
        chk("rr_done_n", n_done0 + n_done1, 4);
        chk("rr_order_n", order_q.size(), 4);
        for (int i = 0; i < order_q.size() && i < 4; i++)
            chk($sformatf("rr_order%0d", i), order_q[i], i % 2);
        chk("rr_gnt_both", n_both, 0);
        chk("rr_rx0", n_rx0, 2);
        chk("rr_rx1", n_rx1, 2);
        chk("rr_mosi_n", mosi_log.size(), 4);
        if (mosi_log.size() == 4)
            chk("rr_mosi", {mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3]}, 32'h10201121);

        // Table: single-requester transactions including zero length and watchdog
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (vecs[k].who) tx_src1[j] = vecs[k].tx[j];
                else             tx_src0[j] = vecs[k].tx[j];
                rx_src[j] = vecs[k].rx[j];
            end
            run_txn(vecs[k].who, vecs[k].len, vecs[k].stuck, vecs[k].exp_err,
                    $sformatf("vec%0d", k));
        end

        // Maximum length: 15 bytes, rem must not wrap
        for (int i = 0; i < 16; i++) begin
            tx_src0[i] = 8'(i * 17);
            rx_src[i]  = 8'(8'hF0 ^ i);
        end
        run_txn(1'b0, 15, 1'b0, 1'b0, "maxlen");

        // Reset during RUN of a 3-byte transaction
        clear_mon();
        for (int i = 0; i < 3; i++) begin tx_src0[i] = 8'hA0 + 8'(i); rx_src[i] = 8'h50 + 8'(i); end
        tx_idx0 = 0; rx_idx = 0; txd0 = tx_src0[0]; master_en = 1'b1;
        len0 = 4'd3; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        b = 0;
        while (!(n_rx0 >= 1 && !spi_start) && b < 2000) begin @(posedge clk); #1; b++; end
        chk("midrst_in_run", spi_start, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_start", spi_start, 1);
        chk("midrst_gnt", {gnt1, gnt0}, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_done", n_done0 + n_done1, 0);
        chk("midrst_no_err", n_err, 0);
        chk("midrst_idle", busy, 0);
        tx_src0[0] = 8'hC3; rx_src[0] = 8'h81;
        run_txn(1'b0, 1, 1'b0, 1'b0, "midrst_fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
